// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32 pipeline hazard logic: FSM state
// encoding of the stall/flush controller, the canonical NOP and x0.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use compare: the instruction in ID reads a register
// that a load currently in EX will write. x0 never creates a hazard.
module hazard_load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i & (ex_rd_i != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline.
// Priority: memory freeze > taken branch > load-use > redirect flush.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       stall_id,
  output logic       flush_id,
  output logic       bubble_ex,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic [1:0] hz_state,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
  output logic [31:0] perf_load_use
`endif
);

  localparam logic [2:0]       REDIR_RELOAD = 3'(REDIRECT_BUBBLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(MEM_TIMEOUT);

  logic             freeze;
  logic             load_use;
  logic             redir_pending;
  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]       redir_cnt_q, redir_cnt_d;
  logic             timeout_q, timeout_d;

  assign freeze        = mem_req & ~mem_ready;
  assign redir_pending = (redir_cnt_q != 3'd0);

  hazard_load_use_detect u_lu (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use)
  );

  // State register: FSM state, wait watchdog, remaining redirect flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      redir_cnt_q <= 3'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic. A freeze parks the redirect count untouched so the
  // flush sequence resumes where it left off once memory responds.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    redir_cnt_d = redir_cnt_q;
    timeout_d   = timeout_q;
    if (freeze) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d >= TIMEOUT_LIM) timeout_d = 1'b1;
    end else if (ex_branch_taken) begin
      redir_cnt_d = REDIR_RELOAD;
      state_d     = (REDIRECT_BUBBLES > 1) ? REDIRECT : RUN;
    end else if (load_use) begin
      // The load-use stall consumes this cycle; any pending flush waits.
      state_d = redir_pending ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      redir_cnt_d = redir_cnt_q - 3'd1;
      state_d     = (redir_cnt_d == 3'd0) ? RUN : REDIRECT;
    end else begin
      state_d = redir_pending ? REDIRECT : RUN;
    end
  end

  // Output decode. Held at zero while reset is asserted, even if the
  // memory is reporting a wait, so stage registers see clean controls.
  always_comb begin
    pc_stall  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    if (reset) begin
      if (freeze) begin
        pc_stall  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (ex_branch_taken) begin
        // The stalled ID instruction is wrong-path, so no load-use stall.
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        pc_stall  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (state_q == REDIRECT) begin
        flush_id = 1'b1;
      end
    end
  end

  assign hz_state    = state_q;
  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic any_stall;
  logic lu_event;

  assign any_stall = pc_stall | stall_id | stall_ex | stall_mem;
  assign lu_event  = pc_stall & ~stall_ex;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating event counters for performance analysis.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
      perf_load_use     <= '0;
    end else begin
      if (any_stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (flush_id)  perf_flush_cycles <= sat_inc(perf_flush_cycles);
      if (lu_event)  perf_load_use     <= sat_inc(perf_load_use);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Instance A uses
// REDIRECT_BUBBLES=2 / MEM_TIMEOUT=3, instance B uses REDIRECT_BUBBLES=3
// with the default MEM_TIMEOUT; both share the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic       a_pc, a_sid, a_fid, a_bex, a_sex, a_smem, a_to;
  logic [1:0] a_st;
  logic       b_pc, b_sid, b_fid, b_bex, b_sex, b_smem, b_to;
  logic [1:0] b_st;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_ps, a_pf, a_pl, b_ps, b_pf, b_pl;
`endif

  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc, a_sid, a_fid, a_bex, a_sex, a_smem};
  assign ctl_b = {b_pc, b_sid, b_fid, b_bex, b_sex, b_smem};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(a_pc), .stall_id(a_sid), .flush_id(a_fid), .bubble_ex(a_bex),
    .stall_ex(a_sex), .stall_mem(a_smem), .hz_state(a_st), .mem_timeout(a_to)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(a_ps), .perf_flush_cycles(a_pf), .perf_load_use(a_pl)
`endif
  );

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(3), .MEM_TIMEOUT(255), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(b_pc), .stall_id(b_sid), .flush_id(b_fid), .bubble_ex(b_bex),
    .stall_ex(b_sex), .stall_mem(b_smem), .hz_state(b_st), .mem_timeout(b_to)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(b_ps), .perf_flush_cycles(b_pf), .perf_load_use(b_pl)
`endif
  );

  // Control vector bit order: {pc_stall, stall_id, flush_id, bubble_ex, stall_ex, stall_mem}
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic br, input logic mreq, input logic mrdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
    mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge, ready for new inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic invariant();
    chk("a_flush_and_stall_id", {31'd0, a_fid & a_sid}, 32'd0);
    chk("b_flush_and_stall_id", {31'd0, b_fid & b_sid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int flushes;

    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};
    vecs[4]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[5]  = '{5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110011};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    vecs[8]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 6'b110011};
    vecs[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110011};
    vecs[12] = '{5'd9, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100};

    // Reset held with memory reporting a wait: outputs must stay quiet.
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl_a", {26'd0, ctl_a}, 32'd0);
    chk("reset_ctl_b", {26'd0, ctl_b}, 32'd0);
    chk("reset_state_a", {30'd0, a_st}, 32'd0);
    chk("reset_timeout_a", {31'd0, a_to}, 32'd0);
    reset = 1'b1;
    #1;
    chk("release_freeze_a", {26'd0, ctl_a}, {26'd0, 6'b110011});
    next_cycle();
    idle();
    for (int i = 0; i < 3; i++) next_cycle();

    // Table of single-cycle hazard vectors, each from RUN with idle recovery.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].mr, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {26'd0, ctl_a}, {26'd0, vecs[i].exp});
      chk($sformatf("vec%0d_state", i), {30'd0, a_st}, 32'd0);
      invariant();
      next_cycle();
      idle();
      for (int k = 0; k < 3; k++) next_cycle();
    end

    // Load-use lasts one cycle: once the load leaves EX the stall is gone.
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_cycle0", {26'd0, ctl_a}, {26'd0, 6'b110100});
    next_cycle();
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lu_cycle1", {26'd0, ctl_a}, 32'd0);
    next_cycle();
    idle();
    next_cycle();

    // Branch and load-use together, REDIRECT_BUBBLES=2 (instance A).
    drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_lu_c0_ctl", {26'd0, ctl_a}, {26'd0, 6'b001100});
    next_cycle();
    idle();
    @(negedge clk);
    chk("br_lu_c1_ctl", {26'd0, ctl_a}, {26'd0, 6'b001000});
    chk("br_lu_c1_state", {30'd0, a_st}, 32'd2);
    invariant();
    next_cycle();
    @(negedge clk);
    chk("br_lu_c2_ctl", {26'd0, ctl_a}, 32'd0);
    chk("br_lu_c2_state", {30'd0, a_st}, 32'd0);
    next_cycle();
    for (int k = 0; k < 3; k++) next_cycle();

    // Four-cycle memory wait on instance B (timeout far away).
    for (int c = 1; c <= 4; c++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("mw_c%0d_ctl", c), {26'd0, ctl_b}, {26'd0, 6'b110011});
      chk($sformatf("mw_c%0d_state", c), {30'd0, b_st}, (c == 1) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mw_ready_ctl", {26'd0, ctl_b}, 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("mw_back_run", {30'd0, b_st}, 32'd0);
    chk("mw_no_timeout_b", {31'd0, b_to}, 32'd0);
    next_cycle();

    // Timeout with MEM_TIMEOUT=3 on instance A, after a fresh reset.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("to_c%0d", c), {31'd0, a_to}, (c >= 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    chk("to_sticky", {31'd0, a_to}, 32'd1);
    chk("to_state_run", {30'd0, a_st}, 32'd0);
    reset = 1'b0;
    #1;
    chk("to_cleared_by_reset", {31'd0, a_to}, 32'd0);
    reset = 1'b1;
    next_cycle();
    next_cycle();

    // Freeze in the middle of a REDIRECT sequence, instance B (3 bubbles).
    flushes = 0;
    for (int c = 1; c <= 7; c++) begin
      case (c)
        1:       drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        3, 4:    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        5:       drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        default: idle();
      endcase
      @(negedge clk);
      if (b_fid) flushes++;
      chk($sformatf("fr_c%0d_flush", c), {31'd0, b_fid},
          (c == 1 || c == 2 || c == 6) ? 32'd1 : 32'd0);
      invariant();
      if (c == 4) chk("fr_c4_state", {30'd0, b_st}, 32'd1);
      if (c == 6) chk("fr_c6_state", {30'd0, b_st}, 32'd2);
      if (c == 7) chk("fr_c7_state", {30'd0, b_st}, 32'd0);
      next_cycle();
    end
    chk("fr_total_flushes", flushes, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
